pc_sequencer: RTL and testbench

//   Registered program-counter unit for the RISC-V core. Generalises next-PC selection with:
//   - conditional branches, JAL and JALR;
//   - trap entry/return with an EPC register and misaligned-target detection;
//   - stall, halt/resume, and a parametrised boot delay after reset.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_target_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM encoding and alignment mask.
// No logic of its own; imported by pc_sequencer and pc_target_calc.
// No flow control; pure type/constant definitions.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Low PC bits that must be zero for a legal fetch target.
    function automatic logic [1:0] align_mask(input bit c_ext);
        return c_ext ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Jump/branch target adder with misalignment detection.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            jalr_i,
    input  logic            jal_i,
    input  logic            branch_i,
    input  logic            taken_i,
    output logic [XLEN-1:0] tgt_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    localparam logic [1:0] ALIGN_MASK = align_mask(C_EXT);

    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] rel_tgt;

    always_comb begin
        jalr_tgt   = (rs1_i + imm_i) & ~XLEN'(1);
        rel_tgt    = pc_i + imm_i;
        tgt_o      = jalr_i ? jalr_tgt : rel_tgt;
        redirect_o = jalr_i | jal_i | (branch_i & taken_i);
        misalign_o = redirect_o && ((tgt_o[1:0] & ALIGN_MASK) != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/trap selection, EPC and halt/boot FSM.
// Latency: a redirect request appears on pc_o one cycle later.
// Backpressure: stall_i freezes pc/epc/state in RUN; HALTED waits for resume_i.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100,
    parameter int              BOOT_DELAY   = 1,
    parameter bit              C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            taken_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic [1:0]      state_o
);

    localparam int            CW        = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_DELAY - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] tgt;
    logic            redirect;
    logic            tgt_misalign;

    pc_target_calc #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_target (
        .pc_i       (pc_q),
        .imm_i      (imm_i),
        .rs1_i      (rs1_i),
        .jalr_i     (jalr_i),
        .jal_i      (jal_i),
        .branch_i   (branch_i),
        .taken_i    (taken_i),
        .tgt_o      (tgt),
        .redirect_o (redirect),
        .misalign_o (tgt_misalign)
    );

    assign pc_plus4_o = pc_q + XLEN'(4);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (trap_i) begin
                        pc_d  = TRAP_VECTOR;
                        epc_d = pc_q;
                    end else if (mret_i) begin
                        pc_d = epc_q;
                    end else if (redirect) begin
                        if (tgt_misalign) begin
                            pc_d       = TRAP_VECTOR;
                            epc_d      = pc_q;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d = tgt;
                        end
                    end else begin
                        pc_d = pc_plus4_o;
                    end
                    // A simultaneous trap cancels the halt request.
                    if (halt_i && !trap_i) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            cnt_q      <= '0;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign epc_o      = epc_q;
    assign misalign_o = misalign_q;
    assign pc_valid_o = (state_q == ST_RUN);
    assign state_o    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (BOOT_DELAY=3, C_EXT=0).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, branch_i, taken_i, jal_i, jalr_i;
    logic [31:0] imm_i, rs1_i;
    logic        trap_i, mret_i, halt_i, resume_i;
    logic [31:0] pc_o, pc_plus4_o, epc_o;
    logic        pc_valid_o, misalign_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .TRAP_VECTOR  (32'h100),
        .BOOT_DELAY   (3),
        .C_EXT        (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .branch_i   (branch_i),
        .taken_i    (taken_i),
        .jal_i      (jal_i),
        .jalr_i     (jalr_i),
        .imm_i      (imm_i),
        .rs1_i      (rs1_i),
        .trap_i     (trap_i),
        .mret_i     (mret_i),
        .halt_i     (halt_i),
        .resume_i   (resume_i),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .pc_valid_o (pc_valid_o),
        .epc_o      (epc_o),
        .misalign_o (misalign_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall_i = 0; branch_i = 0; taken_i = 0; jal_i = 0; jalr_i = 0;
        trap_i = 0; mret_i = 0; halt_i = 0; resume_i = 0;
        imm_i = 0; rs1_i = 0;
    endtask

    task automatic chk_core(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                            input logic mis, input state_e st);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_epc"}, epc_o, epc);
        chk({tag, "_mis"}, 32'(misalign_o), 32'(mis));
        chk({tag, "_st"}, 32'(state_o), 32'(st));
        chk({tag, "_vld"}, 32'(pc_valid_o), 32'(st == ST_RUN));
    endtask

    initial begin
        idle();
        rst_n = 0;
        step(); step();
        chk_core("reset", 32'h0, 32'h0, 1'b0, ST_BOOT);

        // Boot delay: two more edges in BOOT, RUN on the third.
        rst_n = 1;
        step(); chk_core("boot1", 32'h0, 32'h0, 1'b0, ST_BOOT);
        step(); chk_core("boot2", 32'h0, 32'h0, 1'b0, ST_BOOT);
        step(); chk_core("run0", 32'h0, 32'h0, 1'b0, ST_RUN);
        step(); chk("seq4", pc_o, 32'h4);
        step(); chk("seq8", pc_o, 32'h8);
        chk("plus4", pc_plus4_o, 32'hC);

        // Branches around 0x40.
        jal_i = 1; imm_i = 32'h38;
        step(); chk("jal40", pc_o, 32'h40);
        jal_i = 0; branch_i = 1; taken_i = 1; imm_i = 32'hFFFF_FFF8;
        step(); chk_core("br_taken", 32'h38, 32'h0, 1'b0, ST_RUN);
        branch_i = 0; taken_i = 0; jal_i = 1; imm_i = 32'h8;
        step(); chk("back40", pc_o, 32'h40);
        jal_i = 0; branch_i = 1; taken_i = 0; imm_i = 32'hFFFF_FFF9;
        step(); chk_core("br_nt", 32'h44, 32'h0, 1'b0, ST_RUN);

        // JALR: 0x1001+2 -> 0x1002, misaligned for 4-byte alignment.
        branch_i = 0; jalr_i = 1; rs1_i = 32'h1001; imm_i = 32'h2;
        step(); chk_core("jalr_mis", 32'h100, 32'h44, 1'b1, ST_RUN);
        idle();
        step(); chk_core("mis_pulse", 32'h104, 32'h44, 1'b0, ST_RUN);
        jalr_i = 1; rs1_i = 32'h1001; imm_i = 32'h3;
        step(); chk_core("jalr_ok", 32'h1004, 32'h44, 1'b0, ST_RUN);

        // Trap beats JAL; MRET returns to the saved PC.
        idle(); jal_i = 1; imm_i = 32'hFFFF_F07C;
        step(); chk("to80", pc_o, 32'h80);
        trap_i = 1; imm_i = 32'h4;
        step(); chk_core("trap", 32'h100, 32'h80, 1'b0, ST_RUN);
        idle(); mret_i = 1;
        step(); chk_core("mret", 32'h80, 32'h80, 1'b0, ST_RUN);
        idle();
        step(); chk("to84", pc_o, 32'h84);
        branch_i = 1; taken_i = 1; imm_i = 32'h6;
        step(); chk_core("br_mis", 32'h100, 32'h84, 1'b1, ST_RUN);

        // Stall holds everything, JAL lands on the first free edge.
        idle(); stall_i = 1; jal_i = 1; imm_i = 32'hFFFF_FF20;
        for (int i = 0; i < 3; i++) begin
            step(); chk_core("stall", 32'h100, 32'h84, 1'b0, ST_RUN);
        end
        stall_i = 0;
        step(); chk("jal20", pc_o, 32'h20);

        // Halt, ignored inputs, resume.
        idle(); halt_i = 1;
        step(); chk_core("halt", 32'h24, 32'h84, 1'b0, ST_HALTED);
        idle(); jal_i = 1; trap_i = 1; imm_i = 32'h40;
        step(); step(); chk_core("halt_hold", 32'h24, 32'h84, 1'b0, ST_HALTED);
        idle(); resume_i = 1;
        step(); chk_core("resume", 32'h24, 32'h84, 1'b0, ST_RUN);
        idle();
        step(); chk("to28", pc_o, 32'h28);
        halt_i = 1; trap_i = 1;
        step(); chk_core("trap_halt", 32'h100, 32'h28, 1'b0, ST_RUN);

        // Wrap-around at the top of the address space.
        idle(); jal_i = 1; imm_i = 32'hFFFF_FEFC;
        step(); chk("top", pc_o, 32'hFFFF_FFFC);
        chk("plus4_wrap", pc_plus4_o, 32'h0);
        idle();
        step(); chk_core("wrap", 32'h0, 32'h28, 1'b0, ST_RUN);
        halt_i = 1;
        step(); chk_core("halt2", 32'h4, 32'h28, 1'b0, ST_HALTED);

        // Reset while halted, with stall asserted.
        idle(); stall_i = 1; rst_n = 0;
        step(); chk_core("rst_halt", 32'h0, 32'h0, 1'b0, ST_BOOT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
